// File: rtl/sdram_bank_timing_tracker.sv
// Per-bank DRAM state/timing tracker: bank FSMs, tRCD/tRP/tRAS/tRRD_S/tRRD_L/tRFC enforcement,
// per-bank legality vectors and an error pulse for rejected commands.
module sdram_bank_timing_tracker #(
  parameter int unsigned ROW_WIDTH       = 14,
  parameter int unsigned NUM_GROUPS      = 2,
  parameter int unsigned BANKS_PER_GROUP = 2,
  parameter int unsigned BANKS           = NUM_GROUPS * BANKS_PER_GROUP,
  parameter int unsigned T_RCD           = 4,
  parameter int unsigned T_RP            = 4,
  parameter int unsigned T_RAS           = 8,
  parameter int unsigned T_RRD_S         = 2,
  parameter int unsigned T_RRD_L         = 3,
  parameter int unsigned T_RFC           = 10,
  parameter int unsigned CNT_WIDTH       = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  input  logic [1:0]                   cmd_type,
  input  logic [$clog2(BANKS)-1:0]     cmd_bank,
  input  logic [ROW_WIDTH-1:0]         cmd_row,
  output logic                         cmd_ok,
  output logic                         cmd_error,
  output logic [BANKS-1:0]             can_act,
  output logic [BANKS-1:0]             can_pre,
  output logic [BANKS-1:0]             can_rw,
  output logic [BANKS-1:0]             bank_open,
  output logic [BANKS*ROW_WIDTH-1:0]   open_row,
  output logic                         refresh_busy
);

  localparam int unsigned BankW = $clog2(BANKS);

  localparam logic [1:0] CmdAct = 2'b00;
  localparam logic [1:0] CmdPre = 2'b01;
  localparam logic [1:0] CmdRw  = 2'b10;
  localparam logic [1:0] CmdRef = 2'b11;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  // Timers hold the wait remaining after the current cycle, so a command accepted at edge N
  // with constraint T unblocks its dependant at edge N+T.
  localparam cnt_t LdRcd  = cnt_t'(T_RCD - 1);
  localparam cnt_t LdRp   = cnt_t'(T_RP - 1);
  localparam cnt_t LdRas  = cnt_t'(T_RAS - 1);
  localparam cnt_t LdRrdS = cnt_t'(T_RRD_S - 1);
  localparam cnt_t LdRrdL = cnt_t'(T_RRD_L - 1);
  localparam cnt_t LdRfc  = cnt_t'(T_RFC - 1);

  typedef enum logic [1:0] {StIdle, StActivating, StActive, StPrecharging} bank_st_e;

  bank_st_e                 st_q     [BANKS];
  cnt_t                     trcd_q   [BANKS];
  cnt_t                     tras_q   [BANKS];
  cnt_t                     trp_q    [BANKS];
  logic [ROW_WIDTH-1:0]     row_q    [BANKS];
  cnt_t                     trrd_l_q [NUM_GROUPS];
  cnt_t                     trrd_s_q;
  cnt_t                     trfc_q;

  logic [BANKS-1:0]      bank_free;
  logic [BANKS-1:0]      act_fire;
  logic [BANKS-1:0]      pre_fire;
  logic [NUM_GROUPS-1:0] grp_act;
  logic                  bank_in;
  logic                  legal;
  logic                  ref_fire;
  logic                  act_any;

  function automatic cnt_t dec(input cnt_t v);
    return (v == '0) ? v : v - cnt_t'(1);
  endfunction

  assign refresh_busy = (trfc_q != '0);

  // A bank whose countdown has run out is treated as already in its next state.
  always_comb begin
    bank_free = '0;
    bank_open = '0;
    can_pre   = '0;
    can_rw    = '0;
    can_act   = '0;
    for (int b = 0; b < BANKS; b++) begin
      bank_free[b] = (st_q[b] == StIdle) || ((st_q[b] == StPrecharging) && (trp_q[b] == '0));
      bank_open[b] = (st_q[b] == StActivating) || (st_q[b] == StActive);
      can_rw[b]    = (st_q[b] == StActive) || ((st_q[b] == StActivating) && (trcd_q[b] == '0));
      can_pre[b]   = bank_open[b] && (tras_q[b] == '0);
      can_act[b]   = bank_free[b] && !refresh_busy && (trrd_s_q == '0) &&
                     (trrd_l_q[b / BANKS_PER_GROUP] == '0);
    end
  end

  always_comb begin
    open_row = '0;
    for (int b = 0; b < BANKS; b++) begin
      open_row[b*ROW_WIDTH +: ROW_WIDTH] = row_q[b];
    end
  end

  assign bank_in = (32'(cmd_bank) < BANKS);

  always_comb begin
    legal = 1'b0;
    case (cmd_type)
      CmdAct:  legal = bank_in && can_act[cmd_bank];
      CmdPre:  legal = bank_in && can_pre[cmd_bank];
      CmdRw:   legal = bank_in && can_rw[cmd_bank] && (cmd_row == row_q[cmd_bank]);
      CmdRef:  legal = (&bank_free) && !refresh_busy;
      default: legal = 1'b0;
    endcase
  end

  assign cmd_ok   = cmd_valid && legal;
  assign ref_fire = cmd_ok && (cmd_type == CmdRef);

  always_comb begin
    act_fire = '0;
    pre_fire = '0;
    grp_act  = '0;
    for (int b = 0; b < BANKS; b++) begin
      act_fire[b] = cmd_ok && (cmd_type == CmdAct) && (cmd_bank == BankW'(b));
      pre_fire[b] = cmd_ok && (cmd_type == CmdPre) && (cmd_bank == BankW'(b));
      if (act_fire[b]) grp_act[b / BANKS_PER_GROUP] = 1'b1;
    end
  end

  assign act_any = |act_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_error <= 1'b0;
      trrd_s_q  <= '0;
      trfc_q    <= '0;
      for (int g = 0; g < NUM_GROUPS; g++) trrd_l_q[g] <= '0;
      for (int b = 0; b < BANKS; b++) begin
        st_q[b]   <= StIdle;
        trcd_q[b] <= '0;
        tras_q[b] <= '0;
        trp_q[b]  <= '0;
        row_q[b]  <= '0;
      end
    end else begin
      cmd_error <= cmd_valid && !legal;
      trrd_s_q  <= act_any ? LdRrdS : dec(trrd_s_q);
      trfc_q    <= ref_fire ? LdRfc : dec(trfc_q);
      for (int g = 0; g < NUM_GROUPS; g++) begin
        trrd_l_q[g] <= grp_act[g] ? LdRrdL : dec(trrd_l_q[g]);
      end
      for (int b = 0; b < BANKS; b++) begin
        trcd_q[b] <= act_fire[b] ? LdRcd : dec(trcd_q[b]);
        tras_q[b] <= act_fire[b] ? LdRas : dec(tras_q[b]);
        trp_q[b]  <= pre_fire[b] ? LdRp : dec(trp_q[b]);
        if (act_fire[b]) begin
          row_q[b] <= cmd_row;
          st_q[b]  <= StActivating;
        end else if (pre_fire[b]) begin
          st_q[b] <= StPrecharging;
        end else if ((st_q[b] == StActivating) && (trcd_q[b] == '0)) begin
          st_q[b] <= StActive;
        end else if ((st_q[b] == StPrecharging) && (trp_q[b] == '0)) begin
          st_q[b] <= StIdle;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_bank_timing_tracker.sv
// Scoreboard bench for sdram_bank_timing_tracker: stimulus queues expected responses,
// a monitor process compares them at the falling edge.
module tb_sdram_bank_timing_tracker;

  localparam int ROW = 14;
  localparam logic [1:0] C_ACT = 2'b00;
  localparam logic [1:0] C_PRE = 2'b01;
  localparam logic [1:0] C_RW  = 2'b10;
  localparam logic [1:0] C_REF = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_type  = '0;
  logic [1:0]       cmd_bank  = '0;
  logic [ROW-1:0]   cmd_row   = '0;
  logic             cmd_ok, cmd_error, refresh_busy;
  logic [3:0]       can_act, can_pre, can_rw, bank_open;
  logic [4*ROW-1:0] open_row;

  // 16-bank instance with T_RCD=1
  logic              v2 = 1'b0;
  logic [1:0]        t2 = '0;
  logic [3:0]        bk2 = '0;
  logic [ROW-1:0]    row2 = '0;
  logic              ok2, err2, busy2;
  logic [15:0]       can_act2, can_pre2, can_rw2, bank_open2;
  logic [16*ROW-1:0] open_row2;

  sdram_bank_timing_tracker dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_bank(cmd_bank),
    .cmd_row(cmd_row), .cmd_ok(cmd_ok), .cmd_error(cmd_error), .can_act(can_act),
    .can_pre(can_pre), .can_rw(can_rw), .bank_open(bank_open), .open_row(open_row),
    .refresh_busy(refresh_busy)
  );

  sdram_bank_timing_tracker #(.NUM_GROUPS(4), .BANKS_PER_GROUP(4), .T_RCD(1)) dut2 (
    .clk(clk), .rst(rst), .cmd_valid(v2), .cmd_type(t2), .cmd_bank(bk2),
    .cmd_row(row2), .cmd_ok(ok2), .cmd_error(err2), .can_act(can_act2),
    .can_pre(can_pre2), .can_rw(can_rw2), .bank_open(bank_open2), .open_row(open_row2),
    .refresh_busy(busy2)
  );

  typedef struct {
    int          sel;
    int          idx;
    logic [31:0] exp;
  } st_t;

  bit   okq1[$];
  bit   okq2[$];
  st_t  stq[$];
  bit   done = 1'b0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic string sel_name(input int sel);
    case (sel)
      0: return "can_act";
      1: return "can_pre";
      2: return "can_rw";
      3: return "bank_open";
      4: return "refresh_busy";
      5: return "open_row";
      6: return "can_rw2";
      7: return "open_row2";
      default: return "can_act2";
    endcase
  endfunction

  function automatic logic [31:0] st_val(input int sel, input int idx);
    case (sel)
      0: return 32'(can_act);
      1: return 32'(can_pre);
      2: return 32'(can_rw);
      3: return 32'(bank_open);
      4: return 32'(refresh_busy);
      5: return 32'(open_row[idx*ROW +: ROW]);
      6: return 32'(can_rw2);
      7: return 32'(open_row2[idx*ROW +: ROW]);
      default: return 32'(can_act2);
    endcase
  endfunction

  // Monitor: owns every comparison and the counters.
  initial begin : monitor
    bit  pend1;
    bit  pend2;
    bit  e;
    st_t s;
    pend1 = 1'b0;
    pend2 = 1'b0;
    forever begin
      @(negedge clk);
      chk("cmd_error", 32'(cmd_error), 32'(pend1));
      chk("cmd_error2", 32'(err2), 32'(pend2));
      pend1 = 1'b0;
      pend2 = 1'b0;
      if (cmd_valid) begin
        if (okq1.size() == 0) begin
          total++; bad++;
          $display("FAIL okq1: command seen with no expectation queued at %0t", $time);
        end else begin
          e = okq1.pop_front();
          chk("cmd_ok", 32'(cmd_ok), 32'(e));
          pend1 = !e;
        end
      end
      if (v2) begin
        if (okq2.size() == 0) begin
          total++; bad++;
          $display("FAIL okq2: command seen with no expectation queued at %0t", $time);
        end else begin
          e = okq2.pop_front();
          chk("cmd_ok2", 32'(ok2), 32'(e));
          pend2 = !e;
        end
      end
      while (stq.size() > 0) begin
        s = stq.pop_front();
        chk(sel_name(s.sel), st_val(s.sel, s.idx), s.exp);
      end
      if (done) begin
        chk("okq1_left", 32'(okq1.size()), 32'd0);
        chk("okq2_left", 32'(okq2.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    v2 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic cyc(input int two, input logic [1:0] t, input int bank, input int row,
                     input int ok);
    if (two == 0) begin
      cmd_valid = 1'b1; cmd_type = t; cmd_bank = 2'(bank); cmd_row = ROW'(row);
      okq1.push_back(ok != 0);
    end else begin
      v2 = 1'b1; t2 = t; bk2 = 4'(bank); row2 = ROW'(row);
      okq2.push_back(ok != 0);
    end
    step();
  endtask

  task automatic expv(input int sel, input int idx, input logic [31:0] exp);
    st_t s;
    s.sel = sel; s.idx = idx; s.exp = exp;
    stq.push_back(s);
  endtask

  task automatic exp_reset_state();
    expv(0, 0, 'hF); expv(1, 0, 'h0); expv(2, 0, 'h0); expv(3, 0, 'h0); expv(4, 0, 'h0);
    expv(5, 0, 'h0); expv(5, 3, 'h0);
  endtask

  initial begin : stimulus
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_reset_state();
    expv(8, 0, 'hFFFF);
    idle(1);

    // tRCD and row-matched RW; e0 = ACT
    cyc(0, C_ACT, 0, 'h12, 1);
    repeat (3) begin expv(2, 0, 'h0); expv(3, 0, 'h1); idle(1); end
    expv(2, 0, 'h1); expv(1, 0, 'h0); expv(5, 0, 'h12);
    cyc(0, C_RW, 0, 'h12, 1);                  // e4
    cyc(0, C_RW, 0, 'h13, 0);                  // e5 row mismatch
    cyc(0, C_RW, 1, 0, 0);                     // e6 RW to idle bank
    expv(1, 0, 'h0); idle(1);                  // e7 tRAS not yet met
    expv(1, 0, 'h1); cyc(0, C_PRE, 0, 0, 1);   // e8
    idle(4);

    // tRAS / tRP; e0 = ACT
    cyc(0, C_ACT, 0, 'h55, 1);
    idle(4);
    cyc(0, C_PRE, 0, 0, 0);                    // e5 early PRE
    idle(2);
    expv(1, 0, 'h1); cyc(0, C_PRE, 0, 0, 1);   // e8
    expv(0, 0, 'hE); expv(3, 0, 'h0);
    cyc(0, C_PRE, 0, 0, 0);                    // e9 PRE to precharging bank
    expv(0, 0, 'hE); cyc(0, C_PRE, 3, 0, 0);   // e10 PRE to idle bank
    expv(0, 0, 'hE); idle(1);                  // e11
    expv(0, 0, 'hF); idle(1);                  // e12

    // tRRD_S / tRRD_L and refresh; e0 = ACT b0
    cyc(0, C_ACT, 0, 1, 1);
    expv(0, 0, 'h0); cyc(0, C_ACT, 2, 2, 0);   // e1
    expv(0, 0, 'hC); cyc(0, C_ACT, 2, 2, 1);   // e2
    expv(0, 0, 'h0); idle(1);                  // e3
    expv(0, 0, 'h2); cyc(0, C_ACT, 1, 3, 1);   // e4
    expv(3, 0, 'h7); cyc(0, C_REF, 0, 0, 0);   // e5 REF with banks open
    idle(2);
    cyc(0, C_PRE, 0, 0, 1);                    // e8
    idle(1);
    expv(1, 0, 'h4); cyc(0, C_PRE, 2, 0, 1);   // e10
    idle(1);
    cyc(0, C_PRE, 1, 0, 1);                    // e12
    idle(2);
    cyc(0, C_REF, 0, 0, 0);                    // e15 b1 still precharging
    cyc(0, C_REF, 0, 0, 1);                    // e16 = N
    expv(4, 0, 'h1); expv(0, 0, 'h0); idle(1); // N+1
    cyc(0, C_REF, 0, 0, 0);                    // N+2
    idle(6);
    expv(4, 0, 'h1); expv(0, 0, 'h0);
    cyc(0, C_ACT, 3, 'h3ABC, 0);               // N+9
    expv(4, 0, 'h0); expv(0, 0, 'hF);
    cyc(0, C_ACT, 3, 'h3ABC, 1);               // N+10

    // Reset in the middle of the tRCD countdown
    expv(3, 0, 'h8); expv(5, 3, 'h3ABC); idle(1);
    idle(1);
    rst = 1'b1;
    exp_reset_state();
    idle(2);
    rst = 1'b0;
    cyc(0, C_ACT, 3, 5, 1);
    expv(5, 3, 'h5); expv(3, 0, 'h8); idle(1);

    // 16-bank, T_RCD=1 instance
    cyc(1, C_ACT, 0, 'h0AA, 1);
    expv(6, 0, 'h0001); expv(8, 0, 'h0000);
    cyc(1, C_RW, 0, 'h0AA, 1);
    cyc(1, C_ACT, 15, 'h3FFF, 1);
    expv(6, 0, 'h8001); expv(7, 0, 'h0AA); expv(7, 15, 'h3FFF);
    cyc(1, C_RW, 15, 'h3FFF, 1);
    cyc(1, C_RW, 0, 'h3FFF, 0);
    idle(2);
    done = 1'b1;
  end

endmodule

// File: doc/sdram_bank_timing_tracker.md
Name: sdram_bank_timing_tracker

Overview:
- Per-bank DRAM state and timing tracker; the next generation of the memory controller's bank-state logic.
- Models each bank through IDLE / ACTIVATING / ACTIVE / PRECHARGING and enforces tRCD, tRP, tRAS, tRRD_S/tRRD_L (bank-group aware) and all-bank refresh (tRFC).
- Sits between the command scheduler and the DRAM PHY command path. It publishes per-bank legality vectors and rejects illegal commands with an error pulse.

Parameters:
- ROW_WIDTH, 14, row address bits.
- NUM_GROUPS, 2, bank groups.
- BANKS_PER_GROUP, 2, banks per group.
- BANKS, NUM_GROUPS*BANKS_PER_GROUP, total banks (derived).
- T_RCD, 4, ACT to first RD/WR, cycles (>=1).
- T_RP, 4, PRE to next ACT same bank (>=1).
- T_RAS, 8, ACT to PRE same bank (>=T_RCD).
- T_RRD_S, 2, ACT to ACT, different group (>=1).
- T_RRD_L, 3, ACT to ACT, same group (>=T_RRD_S).
- T_RFC, 10, REF to any ACT (>=1).
- CNT_WIDTH, 8, timer width; every T_* parameter must be < 2**CNT_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command presented this cycle.
- cmd_type  in  2  00=ACT, 01=PRE, 10=RW, 11=REF.
- cmd_bank  in  $clog2(BANKS)  flat bank index = group*BANKS_PER_GROUP + bank_in_group; ignored for REF.
- cmd_row  in  ROW_WIDTH  row for ACT; row to match for RW.
- cmd_ok  out  1  combinational: the current command is legal and is accepted at this edge.
- cmd_error  out  1  registered one-cycle pulse, the cycle after an illegal command.
- can_act  out  BANKS  per bank: ACT legal now.
- can_pre  out  BANKS  per bank: PRE legal now.
- can_rw  out  BANKS  per bank: RW legal now (bank ACTIVE and tRCD met).
- bank_open  out  BANKS  bank in ACTIVATING or ACTIVE.
- open_row  out  BANKS*ROW_WIDTH  latched row per bank; bank b occupies bits [b*ROW_WIDTH +: ROW_WIDTH].
- refresh_busy  out  1  tRFC window in progress.

Behaviour:
- Reset, asynchronous: all banks IDLE, every timer 0, open_row 0, cmd_error 0, refresh_busy 0. Outputs after reset: can_act all 1, can_pre 0, can_rw 0, bank_open 0.
- All outputs except cmd_ok and cmd_error decode from registered state only.
- Timing convention: a command accepted at edge N with constraint T makes the dependent command legal from edge N+T onward.
- ACT to bank b (group g) is legal when all of the following hold:
  - b is IDLE and its tRP timer has expired;
  - refresh_busy=0;
  - the global tRRD_S timer is 0;
  - group g's tRRD_L timer is 0.
- Accepted ACT:
  - latches cmd_row into open_row[b];
  - moves b to ACTIVATING;
  - loads b's tRCD timer with T_RCD and its tRAS timer with T_RAS;
  - loads the global tRRD_S timer with T_RRD_S and group g's tRRD_L timer with T_RRD_L.
- ACTIVATING moves to ACTIVE when the tRCD timer reaches 0.
- RW is legal when b is ACTIVE and cmd_row == open_row[b]. An accepted RW changes no state.
- PRE is legal when b is ACTIVATING or ACTIVE and its tRAS timer is 0. PRE to an IDLE or PRECHARGING bank is illegal, never a no-op.
- Accepted PRE: b moves to PRECHARGING, tRP timer loads T_RP, and b returns to IDLE when the timer reaches 0. open_row keeps its value but is not valid.
- REF is legal only when every bank is IDLE (tRP expired) and refresh_busy=0. Accepted REF sets refresh_busy for T_RFC cycles; ACT is blocked for all banks during that window.
- Timers decrement by 1 per cycle and saturate at 0. The decrement and a new load in the same cycle: load wins.
- Illegal command: no state change; cmd_ok=0; cmd_error=1 on the next cycle for exactly one cycle.
- cmd_valid=0: cmd_ok=0 and no error.
- At most one command per cycle; there are no simultaneous commands to resolve.
- Reset asserted mid-timer: all timers clear and every bank returns to IDLE immediately.

Test Plan:
- ACT b0 row 0x12 at edge 0 -> can_rw[0]=0 at edges 1-3 and =1 at edge 4. RW b0 row 0x12 at edge 4 gives cmd_ok=1; RW row 0x13 gives cmd_error at edge 5.
- ACT b0 at edge 0, PRE b0 at edge 5 -> cmd_ok=0 and cmd_error pulse at edge 6. PRE b0 at edge 8 is accepted; can_act[0]=0 through edge 11 and =1 at edge 12.
- tRRD with ACT b0 (group 0) at edge 0:
  - ACT b2 (group 1) at edge 1 -> rejected;
  - ACT b2 at edge 2 -> accepted;
  - ACT b1 (group 0) at edge 4 -> accepted (tRRD_L=3 met at edge 3).
- REF with b1 open -> cmd_error. After all banks are IDLE, REF at edge N -> refresh_busy=1 and can_act=0 through edge N+9; ACT is accepted at edge N+10.
- Assert rst at edge 3 of a tRCD countdown -> all outputs return to their reset values at once. ACT is legal on the first edge after rst deasserts.
- Parameter sweep NUM_GROUPS=4, BANKS_PER_GROUP=4, T_RCD=1 -> RW legal at edge N+1. open_row slices for banks 0 and 15 latch independently.
